// File: rtl/axi_r_pkg.sv
// Shared types for the AXI R-channel beat generator: R word layout, response codes,
// burst and FSM encodings.
package axi_r_pkg;
   localparam int R_W      = 43;
   localparam int ID_MSB   = 42;
   localparam int DATA_MSB = 34;
   localparam int RESP_MSB = 2;
   localparam int LAST_BIT = 0;

   localparam logic [1:0] OKAY   = 2'b00;
   localparam logic [1:0] DECERR = 2'b11;

   typedef enum logic [1:0] {FIXED = 2'b00, INCR = 2'b01, WRAP = 2'b10} burst_e;
   typedef enum logic [1:0] {IDLE, BURST, DRAIN} state_e;
   typedef logic [R_W-1:0] r_word_t;

   // Only power-of-two burst lengths can wrap; anything else degrades to INCR.
   function automatic logic wrap_len_ok(input logic [3:0] len);
      return (len == 4'd1) || (len == 4'd3) || (len == 4'd7) || (len == 4'd15);
   endfunction
endpackage

// File: rtl/r_out_buf.sv
// Two-entry synchronous FIFO of R words sitting between SRAM capture and the async FIFO push.
module r_out_buf
   import axi_r_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       push_i,
   input  logic       pop_i,
   input  r_word_t    din_i,
   output r_word_t    head_o,
   output logic [1:0] count_o
);
   r_word_t    mem_q [2];
   logic       wr_q, rd_q;
   logic [1:0] cnt_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mem_q[0] <= '0;
         mem_q[1] <= '0;
         wr_q     <= 1'b0;
         rd_q     <= 1'b0;
         cnt_q    <= 2'd0;
      end else begin
         if (push_i) begin
            mem_q[wr_q] <= din_i;
            wr_q        <= ~wr_q;
         end
         if (pop_i) rd_q <= ~rd_q;
         cnt_q <= cnt_q + {1'b0, push_i} - {1'b0, pop_i};
      end
   end

   // The issuer never lets push overflow, and pop is only raised when non-empty.
   assign head_o  = (cnt_q != 2'd0) ? mem_q[rd_q] : '0;
   assign count_o = cnt_q;
endmodule

// File: rtl/axi_r_beat_gen.sv
// AXI read-data beat producer: walks one AR burst over a word SRAM and pushes packed
// R words into the R-channel async FIFO, at one beat per cycle when unthrottled.
module axi_r_beat_gen
   import axi_r_pkg::*;
#(
   parameter int ADDR_W = 14,
   parameter int ID_W   = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              arvalid,
   output logic              arready,
   input  logic [ID_W-1:0]   arid,
   input  logic [31:0]       araddr,
   input  logic [3:0]        arlen,
   input  logic [1:0]        arburst,
   output logic              mem_cs,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [31:0]       mem_rdata,
   input  logic              fifo_not_full,
   output logic              fifo_wr_en,
   output logic [R_W-1:0]    fifo_w_data
);
   state_e              state_q, state_d;
   logic [ID_W-1:0]     id_q, id_d;
   logic [ADDR_W-1:0]   addr_q, addr_d, addr_nxt;
   logic [3:0]          len_q, len_d;
   burst_e              mode_q, mode_d;
   logic                err_q, err_d;
   logic [4:0]          issued_q, issued_d;
   logic                infl_q, infl_last_q, infl_last_d;
   logic                issue, push;
   logic [1:0]          buf_cnt;
   logic [2:0]          occ;
   r_word_t             head, cap_word;
   logic [ADDR_W-1:0]   wrap_mask;
   logic                unused_addr_lsb;

   assign unused_addr_lsb = ^araddr[1:0];

   r_out_buf u_buf (
      .clk     (clk),
      .rst     (rst),
      .push_i  (infl_q),
      .pop_i   (push),
      .din_i   (cap_word),
      .head_o  (head),
      .count_o (buf_cnt)
   );

   assign push        = (buf_cnt != 2'd0) && fifo_not_full;
   assign fifo_wr_en  = push;
   assign fifo_w_data = head;
   assign mem_addr    = addr_q;
   assign cap_word    = {id_q, (err_q ? 32'h0 : mem_rdata), (err_q ? DECERR : OKAY), infl_last_q};

   // Slots that will be occupied next cycle; a new issue needs one of them free.
   assign occ = {1'b0, buf_cnt} + {2'b00, infl_q} - {2'b00, push};

   assign wrap_mask = {{(ADDR_W-4){1'b0}}, len_q};
   always_comb begin
      addr_nxt = addr_q;
      case (mode_q)
         FIXED:   addr_nxt = addr_q;
         WRAP:    addr_nxt = (addr_q & ~wrap_mask) | ((addr_q + 1'b1) & wrap_mask);
         default: addr_nxt = addr_q + 1'b1;
      endcase
   end

   always_comb begin
      state_d     = state_q;
      id_d        = id_q;
      addr_d      = addr_q;
      len_d       = len_q;
      mode_d      = mode_q;
      err_d       = err_q;
      issued_d    = issued_q;
      infl_last_d = infl_last_q;
      arready     = (state_q == IDLE);
      issue       = (state_q == BURST) && (issued_q <= {1'b0, len_q}) && (occ < 3'd2);
      mem_cs      = issue && !err_q;
      case (state_q)
         IDLE: if (arvalid) begin
            id_d     = arid;
            addr_d   = araddr[ADDR_W+1:2];
            len_d    = arlen;
            err_d    = |araddr[31:ADDR_W+2];
            issued_d = 5'd0;
            case (arburst)
               2'b00:   mode_d = FIXED;
               2'b10:   mode_d = wrap_len_ok(arlen) ? WRAP : INCR;
               default: mode_d = INCR;
            endcase
            state_d = BURST;
         end
         BURST: if (issue) begin
            addr_d      = addr_nxt;
            issued_d    = issued_q + 5'd1;
            infl_last_d = (issued_q == {1'b0, len_q});
            if (issued_q == {1'b0, len_q}) state_d = DRAIN;
         end
         DRAIN: if (push && head[LAST_BIT]) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         id_q        <= '0;
         addr_q      <= '0;
         len_q       <= '0;
         mode_q      <= INCR;
         err_q       <= 1'b0;
         issued_q    <= '0;
         infl_q      <= 1'b0;
         infl_last_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         id_q        <= id_d;
         addr_q      <= addr_d;
         len_q       <= len_d;
         mode_q      <= mode_d;
         err_q       <= err_d;
         issued_q    <= issued_d;
         infl_q      <= issue;
         infl_last_q <= infl_last_d;
      end
   end
endmodule

// File: tb/tb_axi_r_beat_gen.sv
// Scoreboard bench for axi_r_beat_gen: expected addresses and R words are queued when an
// AR is driven and popped as the DUT issues reads and pushes beats.
module tb_axi_r_beat_gen;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        arvalid = 1'b0;
   logic        arready;
   logic [7:0]  arid = '0;
   logic [31:0] araddr = '0;
   logic [3:0]  arlen = '0;
   logic [1:0]  arburst = '0;
   logic        mem_cs;
   logic [13:0] mem_addr;
   logic [31:0] mem_rdata = '0;
   logic        fifo_not_full = 1'b1;
   logic        fifo_wr_en;
   logic [42:0] fifo_w_data;

   always #5 clk = ~clk;

   axi_r_beat_gen #(.ADDR_W(14), .ID_W(8)) dut (
      .clk(clk), .rst(rst), .arvalid(arvalid), .arready(arready), .arid(arid),
      .araddr(araddr), .arlen(arlen), .arburst(arburst), .mem_cs(mem_cs),
      .mem_addr(mem_addr), .mem_rdata(mem_rdata), .fifo_not_full(fifo_not_full),
      .fifo_wr_en(fifo_wr_en), .fifo_w_data(fifo_w_data)
   );

   logic [31:0] mem [0:16383];
   always @(posedge clk) if (mem_cs) mem_rdata <= mem[mem_addr];

   int          n_cmp = 0, n_bad = 0, push_cnt = 0;
   logic [42:0] expq [$];
   logic [13:0] addrq [$];

   // Scoreboard consumer plus issue-pacing and stall-stability properties.
   int          occ = 0, infl = 0;
   logic        prev_ok = 1'b0, prev_wr = 1'b0;
   logic [42:0] prev_data = '0, ew;
   logic [13:0] ea;
   always @(negedge clk) begin
      if (rst) begin
         occ = 0; infl = 0; prev_ok = 1'b0;
      end else begin
         if (mem_cs) begin
            n_cmp++;
            if (addrq.size() == 0) begin
               n_bad++; $display("FAIL mem_addr: unexpected read of %0d", mem_addr);
            end else begin
               ea = addrq.pop_front();
               if (mem_addr !== ea) begin
                  n_bad++; $display("FAIL mem_addr: got %0d want %0d", mem_addr, ea);
               end
            end
            n_cmp++;
            if (occ + infl - int'(fifo_wr_en) >= 2) begin
               n_bad++; $display("FAIL issue_full: occupancy %0d inflight %0d", occ, infl);
            end
         end
         if (fifo_wr_en) begin
            push_cnt++; n_cmp++;
            if (expq.size() == 0) begin
               n_bad++; $display("FAIL beat: unexpected push %h", fifo_w_data);
            end else begin
               ew = expq.pop_front();
               if (fifo_w_data !== ew) begin
                  n_bad++; $display("FAIL beat: got %h want %h", fifo_w_data, ew);
               end
            end
         end
         if (prev_ok && !prev_wr && prev_data != 0) begin
            n_cmp++;
            if (fifo_w_data !== prev_data) begin
               n_bad++; $display("FAIL stall_stable: got %h want %h", fifo_w_data, prev_data);
            end
         end
         prev_ok = 1'b1; prev_wr = fifo_wr_en; prev_data = fifo_w_data;
         occ = occ + infl - int'(fifo_wr_en);
         if (occ < 0) occ = 0;
         infl = int'(mem_cs);
      end
   end

   task automatic send_ar(input logic [7:0] id, input logic [31:0] addr, input logic [3:0] len,
                          input logic [1:0] burst);
      logic        err, wrap, ok;
      logic [13:0] a;
      logic [31:0] d;
      int          w, size, cnt;
      err  = (addr[31:16] != 16'h0);
      w    = int'(addr[15:2]);
      size = int'(len) + 1;
      wrap = (burst == 2'b10) && (len == 1 || len == 3 || len == 7 || len == 15);
      for (int i = 0; i <= int'(len); i++) begin
         if (burst == 2'b00) a = 14'(w);
         else if (wrap) a = 14'((w / size) * size + ((w % size) + i) % size);
         else a = 14'(w + i);
         if (!err) addrq.push_back(a);
         d = err ? 32'h0 : mem[a];
         expq.push_back({id, d, (err ? 2'b11 : 2'b00), (i == int'(len))});
      end
      @(posedge clk); #1;
      arvalid = 1'b1; arid = id; araddr = addr; arlen = len; arburst = burst;
      cnt = 0;
      do begin
         @(negedge clk); ok = arready;
         @(posedge clk); #1; cnt++;
      end while (!ok && cnt < 200);
      arvalid = 1'b0;
      if (!ok) begin
         n_cmp++; n_bad++; $display("FAIL ar_handshake: no arready within %0d cycles", cnt);
      end
   endtask

   task automatic wait_idle(output int cyc);
      cyc = 0;
      do begin @(negedge clk); cyc++; end while (!arready && cyc < 400);
      if (!arready) begin
         n_cmp++; n_bad++; $display("FAIL idle_timeout: arready still 0 after %0d cycles", cyc);
      end
   endtask

   task automatic test_reset();
      repeat (2) @(negedge clk);
      n_cmp++;
      if (arready !== 1'b1 || mem_cs !== 1'b0 || mem_addr !== 14'd0 ||
          fifo_wr_en !== 1'b0 || fifo_w_data !== 43'd0) begin
         n_bad++;
         $display("FAIL reset_state: arready=%b mem_cs=%b mem_addr=%0d wr_en=%b data=%h want 1 0 0 0 0",
                  arready, mem_cs, mem_addr, fifo_wr_en, fifo_w_data);
      end
      @(posedge clk); #1 rst = 1'b0;
   endtask

   task automatic test_single();
      send_ar(8'h5A, 32'h10, 4'd0, 2'b01);
      @(negedge clk); n_cmp++;
      if (mem_cs !== 1'b1 || mem_addr !== 14'd4) begin
         n_bad++; $display("FAIL t1_read_T+1: mem_cs=%b addr=%0d want 1 4", mem_cs, mem_addr);
      end
      @(negedge clk); n_cmp++;
      if (mem_cs !== 1'b0) begin
         n_bad++; $display("FAIL t1_single_read_T+2: mem_cs=%b want 0", mem_cs);
      end
      @(negedge clk); n_cmp++;
      if (fifo_wr_en !== 1'b1 || fifo_w_data !== {8'h5A, 32'hDEADBEEF, 2'b00, 1'b1}) begin
         n_bad++; $display("FAIL t1_push_T+3: wr_en=%b data=%h want 1 %h", fifo_wr_en, fifo_w_data,
                           {8'h5A, 32'hDEADBEEF, 2'b00, 1'b1});
      end
      @(negedge clk); n_cmp++;
      if (arready !== 1'b1 || fifo_wr_en !== 1'b0) begin
         n_bad++; $display("FAIL t1_ready_T+4: arready=%b wr_en=%b want 1 0", arready, fifo_wr_en);
      end
   endtask

   task automatic test_incr();
      int cyc, p0;
      p0 = push_cnt;
      send_ar(8'h21, 32'h20, 4'd3, 2'b01);
      wait_idle(cyc);
      n_cmp++;
      if (cyc != 7 || push_cnt - p0 != 4) begin
         n_bad++; $display("FAIL incr_rate: idle after %0d cycles with %0d pushes want 7 4", cyc, push_cnt - p0);
      end
   endtask

   task automatic test_wrap();
      int cyc;
      send_ar(8'h3C, 32'h38, 4'd3, 2'b10);
      wait_idle(cyc);
      n_cmp++;
      if (cyc != 7 || expq.size() != 0) begin
         n_bad++; $display("FAIL wrap_done: cycles=%0d left=%0d want 7 0", cyc, expq.size());
      end
   endtask

   task automatic test_backpressure();
      bit pat [6];
      int k, p0;
      pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
      p0 = push_cnt;
      send_ar(8'h4B, 32'h200, 4'd7, 2'b01);
      k = 0;
      do begin
         @(posedge clk); #1 fifo_not_full = pat[k % 6]; k++;
         @(negedge clk);
      end while (!arready && k < 400);
      fifo_not_full = 1'b1;
      n_cmp++;
      if (!arready || push_cnt - p0 != 8 || expq.size() != 0) begin
         n_bad++; $display("FAIL backpressure: arready=%b pushes=%0d left=%0d want 1 8 0",
                           arready, push_cnt - p0, expq.size());
      end
   endtask

   task automatic test_decerr();
      int cyc, p0;
      p0 = push_cnt;
      send_ar(8'h77, 32'h8000_0000, 4'd2, 2'b01);
      wait_idle(cyc);
      n_cmp++;
      if (cyc != 6 || push_cnt - p0 != 3) begin
         n_bad++; $display("FAIL decerr_pacing: cycles=%0d pushes=%0d want 6 3", cyc, push_cnt - p0);
      end
   endtask

   task automatic test_back_to_back();
      int cyc, p0;
      p0 = push_cnt;
      send_ar(8'h11, 32'h40, 4'd2, 2'b00);
      @(negedge clk); n_cmp++;
      if (arready !== 1'b0) begin
         n_bad++; $display("FAIL busy_arready: got %b want 0", arready);
      end
      send_ar(8'h12, 32'hFFF8, 4'd3, 2'b11);
      send_ar(8'h13, 32'h38, 4'd2, 2'b10);
      wait_idle(cyc);
      n_cmp++;
      if (push_cnt - p0 != 10 || expq.size() != 0 || addrq.size() != 0) begin
         n_bad++; $display("FAIL back_to_back: pushes=%0d left=%0d/%0d want 10 0/0",
                           push_cnt - p0, expq.size(), addrq.size());
      end
   endtask

   task automatic test_reset_mid_burst();
      int k, cyc, p0;
      p0 = push_cnt;
      send_ar(8'h33, 32'h400, 4'd15, 2'b01);
      k = 0;
      while (push_cnt < p0 + 5 && k < 100) begin @(posedge clk); k++; end
      #2 rst = 1'b1;
      #1 n_cmp++;
      if (fifo_wr_en !== 1'b0 || mem_cs !== 1'b0 || mem_addr !== 14'd0 || push_cnt - p0 != 5) begin
         n_bad++; $display("FAIL reset_abort: wr_en=%b mem_cs=%b addr=%0d pushes=%0d want 0 0 0 5",
                           fifo_wr_en, mem_cs, mem_addr, push_cnt - p0);
      end
      expq.delete(); addrq.delete();
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk); n_cmp++;
      if (arready !== 1'b1 || fifo_wr_en !== 1'b0) begin
         n_bad++; $display("FAIL post_reset: arready=%b wr_en=%b want 1 0", arready, fifo_wr_en);
      end
      p0 = push_cnt;
      send_ar(8'h44, 32'h24, 4'd0, 2'b01);
      wait_idle(cyc);
      n_cmp++;
      if (push_cnt - p0 != 1 || expq.size() != 0) begin
         n_bad++; $display("FAIL post_reset_beat: pushes=%0d left=%0d want 1 0", push_cnt - p0, expq.size());
      end
   endtask

   initial begin
      for (int i = 0; i < 16384; i++) mem[i] = (i * 32'h9E3779B9) ^ 32'h13572468;
      mem[4] = 32'hDEADBEEF;
      test_reset();
      test_single();
      test_incr();
      test_wrap();
      test_backpressure();
      test_decerr();
      test_back_to_back();
      test_reset_mid_burst();
      n_cmp++;
      if (expq.size() != 0 || addrq.size() != 0) begin
         n_bad++; $display("FAIL drain_end: beats left %0d reads left %0d want 0 0", expq.size(), addrq.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
